// File: rtl/mux_pkg.sv
// Shared types and helpers for the registered N-channel selector family.
package mux_pkg;

  // Arbitration policy: fixed lowest-index-wins, or rotating round-robin.
  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_t;

  // Width of a channel index; a 1-channel or 2-channel selector still needs one bit.
  function automatic int selw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/muxn_rr_if.sv
// Bundle of producer-side and consumer-side signals of muxn_rr.
//
// Handshake semantics: a word moves across a channel on a rising clock edge
// exactly when that channel's valid and ready are both high. A producer holds
// valid and data stable until that edge; ready may be high without valid.
// On the output side out_valid/out_ready follow the same rule.
interface muxn_rr_if
  import mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
);
  localparam int SELW = selw(N_CH);

  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic                  sel_en;
  logic [SELW-1:0]       sel;
  logic [WIDTH-1:0]      out_data;
  logic [SELW-1:0]       out_ch;
  logic                  out_valid;
  logic                  out_ready;

  // Environment side: producers, select control and the consumer.
  modport master (
    output in_data, in_valid, sel_en, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  // Selector side.
  modport slave (
    input  in_data, in_valid, sel_en, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating first-one search: the first set request at or after start_i,
// wrapping from N-1 back to 0.
module rr_pick
  import mux_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = selw(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic          gnt_any_o,
  output logic [IW-1:0] gnt_idx_o
);

  // Scan offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    gnt_any_o = 1'b0;
    gnt_idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      for (int i = 0; i < N; i++) begin
        if (req_i[i] && (((int'(start_i) + k) % N) == i)) begin
          gnt_any_o = 1'b1;
          gnt_idx_o = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/muxn_rr.sv
// N-channel, WIDTH-bit registered selector with a single output stage.
module muxn_rr
  import mux_pkg::*;
#(
  parameter int    N_CH  = 4,
  parameter int    WIDTH = 8,
  parameter mode_t MODE  = MODE_RR
) (
  input  logic      clk,
  input  logic      reset,
  muxn_rr_if.slave  bus
);
  localparam int SELW = selw(N_CH);

  logic [N_CH-1:0]  mask;
  logic [SELW-1:0]  start;
  logic             gnt_any;
  logic [SELW-1:0]  gnt_idx;
  logic             load;
  logic [WIDTH-1:0] word;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_ch_q,    out_ch_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  // Eligible requests: all valids, or only the forced channel (none if out of range).
  always_comb begin
    mask = '0;
    if (!bus.sel_en) begin
      mask = bus.in_valid;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (bus.sel == SELW'(i)) mask[i] = bus.in_valid[i];
      end
    end
  end

  // Fixed priority is the rotating search anchored at channel 0.
  assign start = (MODE == MODE_RR) ? ptr_q : '0;

  rr_pick #(.N(N_CH)) u_pick (
    .req_i     (mask),
    .start_i   (start),
    .gnt_any_o (gnt_any),
    .gnt_idx_o (gnt_idx)
  );

  // The output stage can take a word when empty or draining this cycle.
  assign load = !out_valid_q || bus.out_ready;

  // One-hot ready to the granted channel; silent during reset and stalls.
  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      bus.in_ready[i] = !reset && load && gnt_any && (gnt_idx == SELW'(i));
    end
  end

  // Route the granted channel's word to the output register input.
  always_comb begin
    word = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt_idx == SELW'(i)) word = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // Next state of the output stage and rotation pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (gnt_any) begin
        out_valid_d = 1'b1;
        out_data_d  = word;
        out_ch_d    = gnt_idx;
        if (MODE == MODE_RR) begin
          ptr_d = (gnt_idx == SELW'(N_CH - 1)) ? '0 : gnt_idx + SELW'(1);
        end else begin
          ptr_d = '0;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers; reset discards any held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_muxn_rr.sv
// Bench for muxn_rr: round-robin N=4, fixed-priority N=4 and round-robin N=3
// instances share one stimulus and are each checked against a behavioural model.
module tb_muxn_rr;
  import mux_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic        sel_en;
  logic [1:0]  sel;
  logic        out_ready;

  muxn_rr_if #(.N_CH(4), .WIDTH(8)) if_rr ();
  muxn_rr_if #(.N_CH(4), .WIDTH(8)) if_fx ();
  muxn_rr_if #(.N_CH(3), .WIDTH(8)) if_n3 ();

  assign if_rr.in_data = in_data;       assign if_fx.in_data = in_data;
  assign if_rr.in_valid = in_valid;     assign if_fx.in_valid = in_valid;
  assign if_rr.sel_en = sel_en;         assign if_fx.sel_en = sel_en;
  assign if_rr.sel = sel;               assign if_fx.sel = sel;
  assign if_rr.out_ready = out_ready;   assign if_fx.out_ready = out_ready;
  assign if_n3.in_data = in_data[23:0];
  assign if_n3.in_valid = in_valid[2:0];
  assign if_n3.sel_en = sel_en;
  assign if_n3.sel = sel;
  assign if_n3.out_ready = out_ready;

  muxn_rr #(.N_CH(4), .WIDTH(8), .MODE(MODE_RR))    u_rr (.clk(clk), .reset(rst), .bus(if_rr));
  muxn_rr #(.N_CH(4), .WIDTH(8), .MODE(MODE_FIXED)) u_fx (.clk(clk), .reset(rst), .bus(if_fx));
  muxn_rr #(.N_CH(3), .WIDTH(8), .MODE(MODE_RR))    u_n3 (.clk(clk), .reset(rst), .bus(if_n3));

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q[$];   // {ch, data} words the RR instance owes its consumer

  // Behavioural model state, one entry per instance (0 RR4, 1 FIXED4, 2 RR3).
  logic       m_valid [3];
  logic [7:0] m_data  [3];
  int         m_ch    [3];
  int         m_ptr   [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] elig(input int n);
    logic [3:0] r = 4'h0;
    if (!sel_en) begin
      for (int i = 0; i < n; i++) r[i] = in_valid[i];
    end else if (int'(sel) < n) begin
      r[sel] = in_valid[sel];
    end
    return r;
  endfunction

  // First eligible channel starting from 'start', wrapping modulo n; -1 if none.
  function automatic int pick(input int n, input logic [3:0] m, input int start);
    for (int k = 0; k < n; k++) begin
      int j = (start + k) % n;
      if (m[j]) return j;
    end
    return -1;
  endfunction

  task automatic read_dut(input int d, output logic [3:0] rdy, output logic v,
                          output logic [7:0] dat, output logic [1:0] ch);
    case (d)
      0:       begin rdy = if_rr.in_ready; v = if_rr.out_valid; dat = if_rr.out_data; ch = if_rr.out_ch; end
      1:       begin rdy = if_fx.in_ready; v = if_fx.out_valid; dat = if_fx.out_data; ch = if_fx.out_ch; end
      default: begin rdy = {1'b0, if_n3.in_ready}; v = if_n3.out_valid; dat = if_n3.out_data; ch = if_n3.out_ch; end
    endcase
  endtask

  // Check all instances against the model, advance the model, then step one clock.
  task automatic cycle();
    logic [3:0] m, rdy_e, rdy_g;
    logic       v, ld;
    logic [7:0] dat;
    logic [1:0] ch;
    logic [31:0] dv;
    logic [9:0] front;
    int g, n;
    #1;
    dv = in_data;
    for (int d = 0; d < 3; d++) begin
      n  = (d == 2) ? 3 : 4;
      m  = elig(n);
      ld = !m_valid[d] || out_ready;
      g  = pick(n, m, (d == 1) ? 0 : m_ptr[d]);
      rdy_e = (!rst && ld && g >= 0) ? 4'(1 << g) : 4'h0;
      read_dut(d, rdy_g, v, dat, ch);
      chk($sformatf("in_ready[%0d]", d), 32'(rdy_g), 32'(rdy_e));
      chk($sformatf("out_valid[%0d]", d), 32'(v), 32'(m_valid[d]));
      chk($sformatf("out_data[%0d]", d), 32'(dat), 32'(m_data[d]));
      chk($sformatf("out_ch[%0d]", d), 32'(ch), 32'(m_ch[d]));
      if (d == 0 && !rst && m_valid[0] && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          front = exp_q.pop_front();
          chk("sb_word", 32'({ch, dat}), 32'(front));
        end
      end
      if (rst) begin
        m_valid[d] = 1'b0; m_data[d] = 8'h0; m_ch[d] = 0; m_ptr[d] = 0;
        if (d == 0) exp_q.delete();
      end else if (ld) begin
        if (g >= 0) begin
          m_valid[d] = 1'b1;
          m_data[d]  = dv[g*8 +: 8];
          m_ch[d]    = g;
          if (d != 1) m_ptr[d] = (g + 1) % n;
          if (d == 0) exp_q.push_back({2'(g), dv[g*8 +: 8]});
        end else begin
          m_valid[d] = 1'b0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int d = 0; d < 3; d++) begin
      m_valid[d] = 1'b0; m_data[d] = 8'h0; m_ch[d] = 0; m_ptr[d] = 0;
    end
    rst = 1'b1; in_valid = 4'hF; in_data = 32'hA3A2A1A0;
    sel_en = 1'b0; sel = 2'd0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Reset with every channel requesting: nothing granted, output empty.
    cycle();
    cycle();
    rst = 1'b0;

    // Round-robin rotation with full throughput, including pointer wrap.
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("rr_seq_ch", 32'(if_rr.out_ch), 32'(k % 4));
      chk("rr_seq_data", 32'(if_rr.out_data), 32'(8'hA0 + k % 4));
    end

    // Consumer stall, then release with simultaneous drain and refill.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("stall_ch", 32'(if_rr.out_ch), 32'd3);
      chk("stall_rdy", 32'(if_rr.in_ready), 32'd0);
    end
    out_ready = 1'b1;
    cycle();
    chk("release_ch", 32'(if_rr.out_ch), 32'd0);
    chk("release_valid", 32'(if_rr.out_valid), 32'd1);

    // Forced select, then forced channel idle, then out-of-range for N=3.
    sel_en = 1'b1; sel = 2'd2;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("forced_ch", 32'(if_rr.out_ch), 32'd2);
    end
    in_valid = 4'b1011;
    for (int k = 0; k < 3; k++) cycle();
    chk("forced_idle_valid", 32'(if_rr.out_valid), 32'd0);
    in_valid = 4'hF; sel = 2'd3;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("oor_rdy_n3", 32'(if_n3.in_ready), 32'd0);
    end
    chk("oor_valid_n3", 32'(if_n3.out_valid), 32'd0);

    // Fixed priority starves channel 3 while channel 1 requests.
    sel_en = 1'b0; in_valid = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("fix_ch", 32'(if_fx.out_ch), 32'd1);
      chk("fix_rdy3", 32'(if_fx.in_ready[3]), 32'd0);
    end
    in_valid = 4'b1000;
    cycle();
    chk("fix_ch3", 32'(if_fx.out_ch), 32'd3);

    // Reset while holding a stalled word; first grant afterwards is lowest valid.
    in_valid = 4'hF; out_ready = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    chk("rst_valid", 32'(if_rr.out_valid), 32'd0);
    chk("rst_ch", 32'(if_rr.out_ch), 32'd0);
    rst = 1'b0; in_valid = 4'b0110; out_ready = 1'b1;
    cycle();
    chk("post_rst_rr", 32'(if_rr.out_ch), 32'd1);
    chk("post_rst_n3", 32'(if_n3.out_ch), 32'd1);

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      rst       = ($urandom_range(0, 49) == 0);
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = $urandom;
      sel_en    = ($urandom_range(0, 3) == 0);
      sel       = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
